uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, runtime baud divisor, configurable data width, optional parity and 1 or 2 stop bits. It replaces the fixed 8-bit, one-bit-per-clock transmitter in the UART TX path. Host logic pushes words through a valid/ready handshake. The block serialises them back-to-back, LSB first, on TX_OUT.

## Interface
- DATA_WIDTH, default 8: data bits per frame, legal range 5..9.
- FIFO_DEPTH, default 8: input FIFO entries, power of two, ≥2.
- DIV_WIDTH, default 16: width of baud_div.
- CLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  asynchronous, active-low reset.
- P_DATA  in  DATA_WIDTH  word to transmit.
- Data_Valid  in  1  push request.
- ready  out  1  FIFO not full; a push occurs on an edge where Data_Valid && ready.
- parity_enable  in  1  1 = parity bit inserted.
- parity_type  in  1  0 = even, 1 = odd.
- stop_bits  in  1  0 = one stop bit, 1 = two stop bits.
- baud_div  in  DIV_WIDTH  bit period = baud_div+1 clocks.
- TX_OUT  out  1  serial line, registered, idle high.
- busy  out  1  a frame is on the line.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently stored.

## Operation
- Reset values: TX_OUT=1, busy=0, ready=1, fifo_count=0. FIFO pointers are cleared and the FSM is in IDLE.
- Frame format: start(0), DATA_WIDTH data bits LSB first, optional parity, then 1 or 2 stop bits (1).
- Parity is computed over the popped word: even = XOR of the bits; odd = its inverse.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START when the FIFO is non-empty. The word is popped on this edge.
  - START→DATA after one bit period.
  - DATA→PARITY after DATA_WIDTH bit periods if parity is enabled, otherwise DATA→STOP.
  - PARITY→STOP after one bit period.
  - STOP ends after 1 or 2 bit periods. It then goes to START if the FIFO is non-empty (popping on that edge), otherwise to IDLE.
- Configuration latch: parity_enable, parity_type, stop_bits and baud_div are captured on the IDLE/STOP→START edge. Changes mid-frame take effect on the next frame only.
- Bit timer: a down-counter is loaded with baud_div at each bit start. The bit ends when it reads 0. baud_div=0 gives one clock per bit, which is the legacy rate.
- Bit counter counts 0..DATA_WIDTH-1 in DATA, and 0..stop_bits in STOP.
- FIFO flow control:
  - ready = (fifo_count != FIFO_DEPTH). A push while ready=0 is ignored and does not corrupt contents.
  - A push and a pop on the same edge leave fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- busy is 1 in every state except IDLE.
- Reset asserted mid-frame: TX_OUT goes to 1 and busy to 0 immediately (asynchronously), and the FIFO is flushed. No partial frame resumes after release.

## Timing
- Push accepted at edge k into an empty FIFO while IDLE:
  - fifo_count=1 after edge k.
  - Pop and START occur at edge k+1; TX_OUT=0 and busy=1 are visible after edge k+2 (TX_OUT is registered).
  - fifo_count returns to 0 after edge k+1.
- Each bit holds on TX_OUT for exactly baud_div+1 clocks.
- Frame length = (1 + DATA_WIDTH + parity_enable + 1 + stop_bits) × (baud_div+1) clocks.
- Back-to-back frames: the next start bit follows the last stop bit with zero idle clocks.
- From full: a pop at edge p raises ready after edge p, so a new push can be accepted at edge p+1.
- busy falls in the same cycle TX_OUT returns to idle after the final stop bit with an empty FIFO.

## Structure
- Shared package uart_pkg holds:
  - the tx_state_e enum (IDLE, START, DATA, PARITY, STOP);
  - the PAR_EVEN / PAR_ODD constants;
  - the STOP_1 / STOP_2 constants.
- Sub-module uart_tx_sync_fifo: a synchronous FIFO parametrised by width and depth, with push, pop, full, empty and count outputs and the same CLK/RST. Its read data is valid combinationally while not empty.
- The top level holds the FSM, bit timer, bit counter, shift register, parity and the registered TX_OUT.

## Test plan
- Reset, DATA_WIDTH=8, baud_div=0, no parity, 1 stop bit; push 0xA5 → TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 at one clock per bit. The start bit appears 2 clocks after the push, and busy is high for exactly 10 clocks.
- baud_div=3, parity even, push 0x07 → each bit lasts 4 clocks and the parity bit is 1. With odd parity the same word gives a parity bit of 0.
- stop_bits=1, push 0x00 then 0xFF back-to-back → two stop periods, then the second start bit with no idle gap. fifo_count goes 1,2,1,0 as expected.
- Fill all 8 entries with Data_Valid held high → ready=0 after the 8th push and the 9th word is dropped. After the first pop, ready returns and all 8 words are transmitted in order.
- Change baud_div from 0 to 5 mid-frame → the current frame completes at 1 clock per bit and the next frame uses 6 clocks per bit.
- Assert RST during the DATA state → TX_OUT=1, busy=0 and fifo_count=0 immediately. After release the line stays idle until a new push.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic STOP_1 = 1'b0;
  localparam logic STOP_2 = 1'b1;

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock FIFO. Read data is presented combinationally at the head
// whenever the FIFO is not empty.
module uart_tx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; writes are dropped while full so contents stay intact.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an input FIFO: runtime baud divisor, optional
// parity, one or two stop bits, frames sent back-to-back LSB first.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DATA_WIDTH-1:0]         P_DATA,
  input  logic                          Data_Valid,
  output logic                          ready,
  input  logic                          parity_enable,
  input  logic                          parity_type,
  input  logic                          stop_bits,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  output logic                          TX_OUT,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(DATA_WIDTH);

  tx_state_e             state;
  tx_state_e             state_nx;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop;
  logic [DIV_WIDTH-1:0]  timer;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_bit;
  logic                  par_en_q;
  logic                  stop_q;
  logic                  bit_end;
  logic                  last_data;
  logic                  last_stop;

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] word,
                                       input logic                  odd);
    return (^word) ^ odd;
  endfunction

  uart_tx_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (Data_Valid),
    .pop   (pop),
    .wdata (P_DATA),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign ready     = !fifo_full;
  assign bit_end   = (timer == '0);
  assign last_data = (bit_cnt == CW'(DATA_WIDTH - 1));
  assign last_stop = (bit_cnt == CW'(stop_q));

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic; a word is popped whenever a new frame starts.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nx = START;
          pop      = 1'b1;
        end
      end
      START: begin
        if (bit_end) state_nx = DATA;
      end
      DATA: begin
        if (bit_end && last_data) state_nx = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) state_nx = STOP;
      end
      STOP: begin
        if (bit_end && last_stop) begin
          if (!fifo_empty) begin
            state_nx = START;
            pop      = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bit timer, bit counter and per-frame configuration latch.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      timer    <= '0;
      div_q    <= '0;
      bit_cnt  <= '0;
      par_en_q <= 1'b0;
      stop_q   <= STOP_1;
    end else if (pop) begin
      timer    <= baud_div;
      div_q    <= baud_div;
      bit_cnt  <= '0;
      par_en_q <= parity_enable;
      stop_q   <= stop_bits;
    end else if (state != IDLE) begin
      if (bit_end) begin
        timer   <= div_q;
        bit_cnt <= (state_nx != state) ? '0 : bit_cnt + CW'(1);
      end else begin
        timer <= timer - DIV_WIDTH'(1);
      end
    end
  end

  // Shift register and parity bit, captured from the FIFO head at pop time.
  always_ff @(posedge CLK) begin
    if (pop) begin
      shift   <= fifo_rdata;
      par_bit <= calc_parity(fifo_rdata, parity_type == PAR_ODD);
    end else if (state == DATA && bit_end) begin
      shift <= shift >> 1;
    end
  end

  // Registered line driver and busy flag, one clock behind the FSM state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      TX_OUT <= 1'b1;
      busy   <= 1'b0;
    end else begin
      busy <= (state != IDLE);
      case (state)
        START:   TX_OUT <= 1'b0;
        DATA:    TX_OUT <= shift[0];
        PARITY:  TX_OUT <= par_bit;
        default: TX_OUT <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected frames, a
// line monitor decodes TX_OUT and compares every sampled clock of each frame.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  p_data;
  logic        data_valid;
  logic        ready;
  logic        parity_enable;
  logic        parity_type;
  logic        stop_bits;
  logic [15:0] baud_div;
  logic        tx_out;
  logic        busy;
  logic [3:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par_bit;
    logic       stop2;
    int         div;
    int         gap;
  } exp_t;

  exp_t sb[$];

  uart_tx_fifo #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (8),
    .DIV_WIDTH  (16)
  ) dut (
    .CLK           (clk),
    .RST           (rst_n),
    .P_DATA        (p_data),
    .Data_Valid    (data_valid),
    .ready         (ready),
    .parity_enable (parity_enable),
    .parity_type   (parity_type),
    .stop_bits     (stop_bits),
    .baud_div      (baud_div),
    .TX_OUT        (tx_out),
    .busy          (busy),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line monitor: decodes frames on TX_OUT and checks them against the queue.
  exp_t cur;
  logic exp_bits [0:12];
  int   nbits;
  int   bit_idx;
  int   clk_in_bit;
  int   idle_cnt = 0;
  bit   in_frame = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
      idle_cnt = 0;
      sb.delete();
    end else begin
      if (!in_frame && tx_out == 1'b0) begin
        check("sb_nonempty_at_start", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          if (cur.gap == 0) check("interframe_gap", idle_cnt, 0);
          nbits = 0;
          exp_bits[nbits++] = 1'b0;
          for (int i = 0; i < 8; i++) exp_bits[nbits++] = cur.data[i];
          if (cur.par_en) exp_bits[nbits++] = cur.par_bit;
          exp_bits[nbits++] = 1'b1;
          if (cur.stop2) exp_bits[nbits++] = 1'b1;
          in_frame   = 1'b1;
          bit_idx    = 0;
          clk_in_bit = 0;
        end
      end
      if (in_frame) begin
        check($sformatf("frame_%02h_bit%0d", cur.data, bit_idx), tx_out, exp_bits[bit_idx]);
        clk_in_bit++;
        if (clk_in_bit == cur.div + 1) begin
          clk_in_bit = 0;
          bit_idx++;
          if (bit_idx == nbits) begin
            in_frame = 1'b0;
            idle_cnt = 0;
          end
        end
      end else begin
        idle_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic pb, input int gap);
    exp_t e;
    int   n = 0;
    while (!ready && n < 1000) begin
      tick();
      n++;
    end
    check("push_ready", ready, 1'b1);
    p_data     = d;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    e.data    = d;
    e.par_en  = parity_enable;
    e.par_bit = pb;
    e.stop2   = stop_bits;
    e.div     = int'(baud_div);
    e.gap     = gap;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (sb.size() == 0 && !in_frame && !busy && fifo_count == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check("drain_done", done, 1'b1);
  endtask

  task automatic wait_count(input logic [3:0] v);
    for (int n = 0; n < 500; n++) begin
      if (fifo_count == v) break;
      tick();
    end
    check("fifo_count_seq", fifo_count, v);
  endtask

  initial begin
    int cnt;
    rst_n         = 1'b0;
    p_data        = '0;
    data_valid    = 1'b0;
    parity_enable = 1'b0;
    parity_type   = 1'b0;
    stop_bits     = 1'b0;
    baud_div      = 16'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_tx", tx_out, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_ready", ready, 1'b1);
    check("reset_count", fifo_count, 4'd0);

    // 0xA5, one clock per bit, no parity, one stop bit
    push(8'hA5, 1'b0, -1);
    check("k_count", fifo_count, 4'd1);
    check("k_tx", tx_out, 1'b1);
    check("k_busy", busy, 1'b0);
    tick();
    check("k1_count", fifo_count, 4'd0);
    check("k1_tx", tx_out, 1'b1);
    check("k1_busy", busy, 1'b0);
    tick();
    check("k2_tx_start", tx_out, 1'b0);
    check("k2_busy", busy, 1'b1);
    cnt = 1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (busy) cnt++;
      else break;
    end
    check("busy_len", cnt, 10);
    wait_idle();

    // 0x07 at 4 clocks per bit: even parity 1, odd parity 0
    baud_div      = 16'd3;
    parity_enable = 1'b1;
    parity_type   = 1'b0;
    push(8'h07, 1'b1, -1);
    wait_idle();
    parity_type = 1'b1;
    push(8'h07, 1'b0, -1);
    wait_idle();

    // two stop bits, back-to-back 0x00 then 0xFF queued behind 0x3C
    parity_enable = 1'b0;
    baud_div      = 16'd0;
    stop_bits     = 1'b1;
    push(8'h3C, 1'b0, -1);
    repeat (3) tick();
    push(8'h00, 1'b0, 0);
    check("b2b_count1", fifo_count, 4'd1);
    push(8'hFF, 1'b0, 0);
    check("b2b_count2", fifo_count, 4'd2);
    wait_count(4'd1);
    wait_count(4'd0);
    wait_idle();

    // fill the FIFO with Data_Valid held; the ninth word is dropped
    stop_bits = 1'b0;
    baud_div  = 16'd2;
    push(8'h11, 1'b0, -1);
    repeat (2) tick();
    for (int i = 0; i < 9; i++) begin
      exp_t e;
      p_data     = 8'h20 + 8'(i);
      data_valid = 1'b1;
      tick();
      if (i < 8) begin
        e.data = p_data; e.par_en = 1'b0; e.par_bit = 1'b0;
        e.stop2 = 1'b0; e.div = 2; e.gap = 0;
        sb.push_back(e);
      end
      if (i == 7) begin
        check("full_ready", ready, 1'b0);
        check("full_count", fifo_count, 4'd8);
      end
      if (i == 8) begin
        check("drop_ready", ready, 1'b0);
        check("drop_count", fifo_count, 4'd8);
      end
    end
    data_valid = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (ready) break;
      tick();
    end
    check("ready_after_pop", ready, 1'b1);
    check("count_after_pop", fifo_count, 4'd7);
    wait_idle();

    // baud_div changes mid-frame: only the next frame slows down
    baud_div = 16'd0;
    push(8'h5A, 1'b0, -1);
    repeat (3) tick();
    baud_div = 16'd5;
    push(8'hC3, 1'b0, 0);
    wait_idle();

    // reset during DATA flushes the FIFO and idles the line
    baud_div = 16'd3;
    push(8'h55, 1'b0, -1);
    push(8'h66, 1'b0, 0);
    repeat (8) tick();
    check("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_tx", tx_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", fifo_count, 4'd0);
    check("rst_ready", ready, 1'b1);
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 30; n++) begin
      tick();
      check("post_rst_tx", tx_out, 1'b1);
      check("post_rst_busy", busy, 1'b0);
    end
    push(8'h81, 1'b0, -1);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
